// File: rtl/countdown_timer.sv
// countdown_timer: loadable min:sec countdown with start/stop/pause and expiry flags
//   clk, rst          clock, synchronous active-high reset
//   tick              count strobe, honoured only while running
//   load, load_min/sec  load a time (clamped to MAX_MIN:59), refused while running
//   start, stop       begin/resume counting, pause counting
//   min, sec          remaining time
//   running           counting, done one-cycle expiry pulse, expired held until load/rst
module countdown_timer #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  localparam logic [5:0] MAXM = 6'(MAX_MIN);
  state_t     r_state, w_state;
  logic [5:0] r_min, r_sec, w_min, w_sec;
  logic       r_running, r_done, r_expired, w_done, w_zero;
  assign w_zero = (r_min == 6'd0) && (r_sec == 6'd0);
  // A refused command (load in RUN, start in RUN) does not mask lower-priority inputs.
  always_comb begin
    w_state = r_state;
    w_min   = r_min;
    w_sec   = r_sec;
    w_done  = 1'b0;
    if (load && r_state != RUN) begin
      w_state = IDLE;
      w_min   = load_min > MAXM ? MAXM : load_min;
      w_sec   = load_sec > 6'd59 ? 6'd59 : load_sec;
    end else if (stop) begin
      w_state = r_state == RUN ? PAUSE : r_state;
    end else if (start && r_state != RUN) begin
      w_state = (r_state == IDLE || r_state == PAUSE) && !w_zero ? RUN : r_state;
    end else if (tick && r_state == RUN) begin
      w_sec = r_sec == 6'd0 ? 6'd59 : r_sec - 6'd1;
      w_min = r_sec == 6'd0 ? r_min - 6'd1 : r_min;
      if (r_min == 6'd0 && r_sec == 6'd1) begin
        w_state = EXPIRED;
        w_done  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_min     <= w_min;
      r_sec     <= w_sec;
      r_running <= w_state == RUN;
      r_done    <= w_done;
      r_expired <= w_state == EXPIRED;
    end
  end
  assign min     = r_min;
  assign sec     = r_sec;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: random and directed stimulus checked against a total-seconds reference model
module tb_countdown_timer;
  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [5:0] load_min = 6'd0, load_sec = 6'd0;
  logic [5:0] min, sec;
  logic       running, done, expired;
  int checks = 0, errors = 0;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  int m_t = 0, m_st = S_IDLE;
  bit m_done = 1'b0;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .min(min), .sec(sec), .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model();
    m_done = 1'b0;
    if (rst) begin
      m_t = 0;
      m_st = S_IDLE;
    end else if (load && m_st != S_RUN) begin
      m_t = (load_min > 59 ? 59 : int'(load_min)) * 60 + (load_sec > 59 ? 59 : int'(load_sec));
      m_st = S_IDLE;
    end else if (stop) begin
      if (m_st == S_RUN) m_st = S_PAUSE;
    end else if (start && m_st != S_RUN) begin
      if ((m_st == S_IDLE || m_st == S_PAUSE) && m_t != 0) m_st = S_RUN;
    end else if (tick && m_st == S_RUN) begin
      m_t--;
      if (m_t == 0) begin
        m_st = S_EXP;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input int lm, input int ls, input bit s, input bit sp, input bit tk);
    rst = r; load = ld; load_min = 6'(lm); load_sec = 6'(ls); start = s; stop = sp; tick = tk;
    @(posedge clk);
    model();
    #1;
    chk("min", 32'(min), 32'(m_t / 60));
    chk("sec", 32'(sec), 32'(m_t % 60));
    chk("running", 32'(running), 32'(m_st == S_RUN));
    chk("done", 32'(done), 32'(m_done));
    chk("expired", 32'(expired), 32'(m_st == S_EXP));
    rst = 0; load = 0; start = 0; stop = 0; tick = 0;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("reset_min", 32'(min), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1'($urandom));
    // 01:02 counts through the minute wrap
    cyc(0, 1, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_min", 32'(min), 0);
    chk("wrap_sec", 32'(sec), 59);
    chk("wrap_run", 32'(running), 1);
    // expiry, then sticky until a load
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("exp_done", 32'(done), 1);
    chk("exp_flag", 32'(expired), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("exp_done_once", 32'(done), 0);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("exp_hold", 32'(expired), 1);
    cyc(0, 1, 0, 5, 0, 0, 0);
    chk("exp_clear", 32'(expired), 0);
    chk("reload_sec", 32'(sec), 5);
    // clamping, load refused in RUN, start at 00:00
    cyc(0, 1, 63, 63, 0, 0, 0);
    chk("clamp_min", 32'(min), 59);
    chk("clamp_sec", 32'(sec), 59);
    cyc(0, 1, 0, 41, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 20, 0, 0, 1);
    chk("load_in_run", 32'(sec), 39);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("start_zero", 32'(running), 0);
    // stop beats tick, pause holds, resume
    cyc(0, 1, 0, 11, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("stop_tick_sec", 32'(sec), 10);
    chk("stop_tick_run", 32'(running), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    chk("stop_beats_start", 32'(running), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("resume_sec", 32'(sec), 9);
    // reset mid-count beats everything
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 31, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 5, 5, 0, 0, 1);
    chk("rst_sec", 32'(sec), 0);
    chk("rst_run", 32'(running), 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
